// File: rtl/hazard_pkg.sv
// Shared types and constants for the MIPS pipeline hazard controller.
// Imported by the load-use detector and the controller top.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    BUBBLE  = 2'd1,
    MEMWAIT = 2'd2
  } hz_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_controller_if.sv
// Pipeline-control bus between the hazard controller and the datapath.
// The datapath side (master) drives the hazard inputs; the controller (slave) drives the enables.
interface hazard_controller_if #(
  parameter int PERF_W = 16
);

  logic              idExMemRead;
  logic [4:0]        idExAddressRt;
  logic [4:0]        ifIdAddressRs;
  logic [4:0]        ifIdAddressRt;
  logic              ifIdUsesRt;
  logic              branchTaken;
  logic              memBusy;
  logic              pcWrite;
  logic              ifIdWrite;
  logic              ifIdFlush;
  logic              idExHazard;
  logic              stallAll;
  logic              memTimeoutErr;
  logic [PERF_W-1:0] stallCycles;
  logic [PERF_W-1:0] flushCount;

  modport master (
    output idExMemRead, idExAddressRt, ifIdAddressRs, ifIdAddressRt,
           ifIdUsesRt, branchTaken, memBusy,
    input  pcWrite, ifIdWrite, ifIdFlush, idExHazard, stallAll,
           memTimeoutErr, stallCycles, flushCount
  );

  modport slave (
    input  idExMemRead, idExAddressRt, ifIdAddressRs, ifIdAddressRt,
           ifIdUsesRt, branchTaken, memBusy,
    output pcWrite, ifIdWrite, ifIdFlush, idExHazard, stallAll,
           memTimeoutErr, stallCycles, flushCount
  );

endinterface

// File: rtl/hazard_controller_load_use_detector.sv
// Combinational load-use detector: the load in EX writes a register the ID instruction reads.
// Loads into $zero never create a dependency.
module load_use_detector
  import hazard_pkg::*;
(
  input  logic       idExMemRead,
  input  logic [4:0] idExAddressRt,
  input  logic [4:0] ifIdAddressRs,
  input  logic [4:0] ifIdAddressRt,
  input  logic       ifIdUsesRt,
  output logic       loadUse
);

  assign loadUse = idExMemRead && (idExAddressRt != REG_ZERO) &&
                   ((idExAddressRt == ifIdAddressRs) ||
                    (ifIdUsesRt && (idExAddressRt == ifIdAddressRt)));

endmodule

// File: rtl/hazard_controller.sv
// Hazard controller: load-use bubbles, taken-branch flush and memory-busy freeze with timeout.
// Define HAZARD_PERF_COUNTERS_EN to build the stallCycles/flushCount performance counters.
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int LOAD_USE_BUBBLES = 1,
  parameter int MEM_TIMEOUT      = 255,
  parameter int TO_W             = 8,
  parameter int PERF_W           = 16
) (
  input  logic         clk,
  input  logic         reset,
  hazard_controller_if.slave bus
);

  hz_state_t         state_q, state_d;
  hz_state_t         resume_q, resume_d;
  logic [3:0]        bub_q, bub_d;
  logic [TO_W-1:0]   wait_q, wait_d;
  logic              err_q, err_d;

  logic              load_use;
  logic              pc_write;
  logic              if_id_write;
  logic              if_id_flush;
  logic              id_ex_hazard;
  logic              stall_all;

  load_use_detector u_load_use (
    .idExMemRead   (bus.idExMemRead),
    .idExAddressRt (bus.idExAddressRt),
    .ifIdAddressRs (bus.ifIdAddressRs),
    .ifIdAddressRt (bus.ifIdAddressRt),
    .ifIdUsesRt    (bus.ifIdUsesRt),
    .loadUse       (load_use)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= RUN;
      resume_q <= RUN;
      bub_q    <= 4'd0;
      wait_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      resume_q <= resume_d;
      bub_q    <= bub_d;
      wait_q   <= wait_d;
      err_q    <= err_d;
    end
  end

  // The bubble counter is left untouched while in MEMWAIT so BUBBLE resumes where it stopped.
  always_comb begin
    state_d  = state_q;
    resume_d = resume_q;
    bub_d    = bub_q;
    wait_d   = wait_q;
    err_d    = err_q;
    case (state_q)
      RUN: begin
        if (bus.memBusy) begin
          state_d  = MEMWAIT;
          wait_d   = TO_W'(1);
          resume_d = RUN;
        end else if (bus.branchTaken) begin
          state_d = RUN;
        end else if (load_use && (LOAD_USE_BUBBLES > 1)) begin
          state_d = BUBBLE;
          bub_d   = 4'(LOAD_USE_BUBBLES - 1);
        end
      end
      BUBBLE: begin
        if (bus.memBusy) begin
          state_d  = MEMWAIT;
          wait_d   = TO_W'(1);
          resume_d = BUBBLE;
        end else if (bus.branchTaken) begin
          state_d = RUN;
        end else begin
          bub_d = bub_q - 4'd1;
          if (bub_q == 4'd1) state_d = RUN;
        end
      end
      MEMWAIT: begin
        if (!bus.memBusy) begin
          state_d = resume_q;
          wait_d  = '0;
        end else if (wait_q == TO_W'(MEM_TIMEOUT)) begin
          err_d   = 1'b1;
          state_d = resume_q;
          wait_d  = '0;
        end else if (wait_q != '1) begin
          wait_d = wait_q + TO_W'(1);
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_hazard = 1'b0;
    stall_all    = 1'b0;
    case (state_q)
      RUN: begin
        if (bus.memBusy) begin
          stall_all = 1'b1;
        end else if (bus.branchTaken) begin
          if_id_flush  = 1'b1;
          id_ex_hazard = 1'b1;
          pc_write     = 1'b1;
          if_id_write  = 1'b1;
        end else if (load_use) begin
          id_ex_hazard = 1'b1;
        end else begin
          pc_write    = 1'b1;
          if_id_write = 1'b1;
        end
      end
      BUBBLE: begin
        if (bus.memBusy) begin
          stall_all = 1'b1;
        end else if (bus.branchTaken) begin
          if_id_flush  = 1'b1;
          id_ex_hazard = 1'b1;
          pc_write     = 1'b1;
          if_id_write  = 1'b1;
        end else begin
          id_ex_hazard = 1'b1;
        end
      end
      MEMWAIT: stall_all = 1'b1;
      default: begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
      end
    endcase
  end

  assign bus.pcWrite       = pc_write;
  assign bus.ifIdWrite     = if_id_write;
  assign bus.ifIdFlush     = if_id_flush;
  assign bus.idExHazard    = id_ex_hazard;
  assign bus.stallAll      = stall_all;
  assign bus.memTimeoutErr = err_q;

`ifdef HAZARD_PERF_COUNTERS_EN
  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [PERF_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_write && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + PERF_W'(1);
    if (if_id_flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + PERF_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.stallCycles = stall_cnt_q;
  assign bus.flushCount  = flush_cnt_q;
`else
  assign bus.stallCycles = {PERF_W{1'b0}};
  assign bus.flushCount  = {PERF_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: two instances (1 and 3 load-use bubbles) driven
// with the same directed and random stimulus and compared against a cycle-level reference model.
module tb_hazard_controller;

  localparam int PERF_W      = 16;
  localparam int MEM_TIMEOUT = 255;

  logic       clk      = 1'b0;
  logic       reset    = 1'b1;
  logic       mem_read = 1'b0;
  logic [4:0] ex_rt    = 5'd0;
  logic [4:0] id_rs    = 5'd0;
  logic [4:0] id_rt    = 5'd0;
  logic       uses_rt  = 1'b0;
  logic       branch   = 1'b0;
  logic       busy     = 1'b0;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  hazard_controller_if #(.PERF_W(PERF_W)) if1 ();
  hazard_controller_if #(.PERF_W(PERF_W)) if3 ();

  assign if1.idExMemRead   = mem_read;
  assign if1.idExAddressRt = ex_rt;
  assign if1.ifIdAddressRs = id_rs;
  assign if1.ifIdAddressRt = id_rt;
  assign if1.ifIdUsesRt    = uses_rt;
  assign if1.branchTaken   = branch;
  assign if1.memBusy       = busy;
  assign if3.idExMemRead   = mem_read;
  assign if3.idExAddressRt = ex_rt;
  assign if3.ifIdAddressRs = id_rs;
  assign if3.ifIdAddressRt = id_rt;
  assign if3.ifIdUsesRt    = uses_rt;
  assign if3.branchTaken   = branch;
  assign if3.memBusy       = busy;

  hazard_controller #(.LOAD_USE_BUBBLES(1), .MEM_TIMEOUT(MEM_TIMEOUT), .TO_W(8), .PERF_W(PERF_W))
    dut1 (.clk(clk), .reset(reset), .bus(if1.slave));
  hazard_controller #(.LOAD_USE_BUBBLES(3), .MEM_TIMEOUT(MEM_TIMEOUT), .TO_W(8), .PERF_W(PERF_W))
    dut3 (.clk(clk), .reset(reset), .bus(if3.slave));

  // Observed outputs packed as {pcWrite, ifIdWrite, ifIdFlush, idExHazard, stallAll}.
  logic [4:0]        act     [2];
  logic              act_err [2];
  logic [PERF_W-1:0] act_sc  [2];
  logic [PERF_W-1:0] act_fc  [2];

  assign act[0]     = {if1.pcWrite, if1.ifIdWrite, if1.ifIdFlush, if1.idExHazard, if1.stallAll};
  assign act[1]     = {if3.pcWrite, if3.ifIdWrite, if3.ifIdFlush, if3.idExHazard, if3.stallAll};
  assign act_err[0] = if1.memTimeoutErr;
  assign act_err[1] = if3.memTimeoutErr;
  assign act_sc[0]  = if1.stallCycles;
  assign act_sc[1]  = if3.stallCycles;
  assign act_fc[0]  = if1.flushCount;
  assign act_fc[1]  = if3.flushCount;

  // Reference model: bubbles still owed, whether memory is being waited on and for how long.
  int         m_left [2], m_len [2], m_stall [2], m_flush [2];
  bit         m_wait [2], m_err [2];
  int         n_left [2], n_len [2], n_stall [2], n_flush [2];
  bit         n_wait [2], n_err [2];
  logic [4:0] exp_v  [2];

  function automatic int lub(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic logic [4:0] msk(input int i);
    return exp_v[i][2] ? 5'b10111 : 5'b11111;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_left[i] = 0; m_len[i] = 0; m_stall[i] = 0; m_flush[i] = 0;
      m_wait[i] = 1'b0; m_err[i] = 1'b0;
    end
  endtask

  task automatic model_outputs();
    bit lu, pc, ifid, fl, hz, st;
    lu = mem_read && (ex_rt != 5'd0) && ((ex_rt == id_rs) || (uses_rt && (ex_rt == id_rt)));
    for (int i = 0; i < 2; i++) begin
      pc = 0; ifid = 0; fl = 0; hz = 0; st = 0;
      n_left[i] = m_left[i]; n_len[i] = m_len[i];
      n_wait[i] = m_wait[i]; n_err[i] = m_err[i];
      if (m_wait[i]) begin
        st = 1;
        if (!busy) begin
          n_wait[i] = 0; n_len[i] = 0;
        end else if (m_len[i] == MEM_TIMEOUT) begin
          n_err[i] = 1; n_wait[i] = 0; n_len[i] = 0;
        end else begin
          n_len[i] = m_len[i] + 1;
        end
      end else if (busy) begin
        st = 1; n_wait[i] = 1; n_len[i] = 1;
      end else if (branch) begin
        fl = 1; hz = 1; pc = 1; ifid = 1; n_left[i] = 0;
      end else if (m_left[i] > 0) begin
        hz = 1; n_left[i] = m_left[i] - 1;
      end else if (lu) begin
        hz = 1; n_left[i] = lub(i) - 1;
      end else begin
        pc = 1; ifid = 1;
      end
      exp_v[i]   = {pc, ifid, fl, hz, st};
      n_stall[i] = m_stall[i];
      n_flush[i] = m_flush[i];
`ifdef HAZARD_PERF_COUNTERS_EN
      if (!pc && (m_stall[i] < (1 << PERF_W) - 1)) n_stall[i] = m_stall[i] + 1;
      if (fl && (m_flush[i] < (1 << PERF_W) - 1)) n_flush[i] = m_flush[i] + 1;
`endif
    end
  endtask

  task automatic model_commit();
    for (int i = 0; i < 2; i++) begin
      m_left[i] = n_left[i]; m_len[i] = n_len[i];
      m_wait[i] = n_wait[i]; m_err[i] = n_err[i];
      m_stall[i] = n_stall[i]; m_flush[i] = n_flush[i];
    end
  endtask

  task automatic sample();
    @(negedge clk);
    model_outputs();
  endtask

  task automatic tick();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    mem_read = 0; ex_rt = 0; id_rs = 0; id_rt = 0; uses_rt = 0; branch = 0; busy = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    #3 reset = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (act[i] !== 5'b11000 || act_err[i] !== 1'b0 || act_sc[i] !== '0 || act_fc[i] !== '0) begin
        miscompares++;
        $display("[TB] FAIL reset dut%0d: outputs %b err %b sc %0d fc %0d, want 11000 err 0 sc 0 fc 0",
                 i, act[i], act_err[i], act_sc[i], act_fc[i]);
      end
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_load_use();
    mem_read = 1; ex_rt = 5'd8; id_rs = 5'd8;
    for (int c = 0; c < 4; c++) begin
      sample();
      if (c == 0 || c == 1) begin
        vectors++;
        if (act[0][4] !== (c == 1) || act[0][1] !== (c == 0)) begin
          miscompares++;
          $display("[TB] FAIL load_use_one_bubble cycle %0d: pcWrite %b idExHazard %b, want %b %b",
                   c, act[0][4], act[0][1], (c == 1), (c == 0));
        end
      end
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if ((act[i] & msk(i)) !== (exp_v[i] & msk(i))) begin
          miscompares++;
          $display("[TB] FAIL load_use dut%0d cycle %0d: got %b want %b", i, c, act[i], exp_v[i]);
        end
      end
      tick();
      clear_inputs();
    end
  endtask

  task automatic test_zero_load();
    mem_read = 1; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0; uses_rt = 1;
    for (int c = 0; c < 2; c++) begin
      sample();
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (act[i][4] !== 1'b1 || act[i][1] !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL zero_load dut%0d: pcWrite %b idExHazard %b, want 1 0", i, act[i][4], act[i][1]);
        end
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_branch_vs_load_use();
    int fc_before [2];
    for (int i = 0; i < 2; i++) fc_before[i] = m_flush[i];
    mem_read = 1; ex_rt = 5'd5; id_rt = 5'd5; uses_rt = 1; branch = 1;
    sample();
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (act[i][4] !== 1'b1 || act[i][2] !== 1'b1 || act[i][1] !== 1'b1 || act[i][0] !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL branch_vs_load_use dut%0d: got %b want pc=1 flush=1 hazard=1 stall=0", i, act[i]);
      end
    end
    tick();
    clear_inputs();
    sample();
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (act[i] !== 5'b11000) begin
        miscompares++;
        $display("[TB] FAIL branch_stays_run dut%0d: got %b want 11000", i, act[i]);
      end
`ifdef HAZARD_PERF_COUNTERS_EN
      vectors++;
      if (act_fc[i] !== PERF_W'(fc_before[i] + 1)) begin
        miscompares++;
        $display("[TB] FAIL branch_flush_count dut%0d: got %0d want %0d", i, act_fc[i], fc_before[i] + 1);
      end
`endif
    end
    tick();
  endtask

  task automatic test_membusy_in_bubble();
    mem_read = 1; ex_rt = 5'd9; id_rs = 5'd9;
    for (int c = 0; c < 9; c++) begin
      busy = (c >= 2 && c <= 4);
      sample();
      if (c >= 2 && c <= 4) begin
        vectors++;
        if (act[1][0] !== 1'b1) begin
          miscompares++;
          $display("[TB] FAIL bubble_membusy_stall cycle %0d: stallAll %b want 1", c, act[1][0]);
        end
      end
      if (c == 6) begin
        vectors++;
        if (act[1][1] !== 1'b1 || act[1][4] !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL bubble_resume: idExHazard %b pcWrite %b, want 1 0", act[1][1], act[1][4]);
        end
      end
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if ((act[i] & msk(i)) !== (exp_v[i] & msk(i))) begin
          miscompares++;
          $display("[TB] FAIL bubble_membusy dut%0d cycle %0d: got %b want %b", i, c, act[i], exp_v[i]);
        end
      end
      tick();
      mem_read = 0;
    end
    clear_inputs();
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      mem_read = 1'($urandom_range(0, 1));
      ex_rt    = 5'($urandom_range(0, 3));
      id_rs    = 5'($urandom_range(0, 3));
      id_rt    = 5'($urandom_range(0, 3));
      uses_rt  = 1'($urandom_range(0, 1));
      branch   = ($urandom_range(0, 6) == 0);
      busy     = ($urandom_range(0, 9) == 0);
      sample();
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if ((act[i] & msk(i)) !== (exp_v[i] & msk(i)) || act_err[i] !== m_err[i] ||
            act_sc[i] !== PERF_W'(m_stall[i]) || act_fc[i] !== PERF_W'(m_flush[i])) begin
          miscompares++;
          $display("[TB] FAIL random dut%0d cycle %0d: got %b err %b sc %0d fc %0d, want %b err %b sc %0d fc %0d",
                   i, c, act[i], act_err[i], act_sc[i], act_fc[i],
                   exp_v[i], m_err[i], m_stall[i], m_flush[i]);
        end
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_mem_timeout();
    busy = 1;
    for (int c = 0; c < 300; c++) begin
      sample();
      if (c == 250) begin
        vectors++;
        if (act_err[0] !== 1'b0 || act_err[1] !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL timeout_early: err %b %b want 0 0", act_err[0], act_err[1]);
        end
      end
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if ((act[i] & msk(i)) !== (exp_v[i] & msk(i)) || act_err[i] !== m_err[i]) begin
          miscompares++;
          $display("[TB] FAIL timeout dut%0d cycle %0d: got %b err %b want %b err %b",
                   i, c, act[i], act_err[i], exp_v[i], m_err[i]);
        end
      end
      tick();
    end
    busy = 0;
    repeat (3) begin
      sample();
      tick();
    end
    sample();
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (act_err[i] !== 1'b1 || act[i] !== 5'b11000) begin
        miscompares++;
        $display("[TB] FAIL timeout_sticky dut%0d: err %b outputs %b, want 1 11000", i, act_err[i], act[i]);
      end
    end
    tick();
  endtask

  task automatic test_async_reset();
    busy = 1;
    repeat (2) begin
      sample();
      tick();
    end
    #2;
    busy  = 0;
    reset = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (act[i] !== 5'b11000 || act_err[i] !== 1'b0 || act_sc[i] !== '0 || act_fc[i] !== '0) begin
        miscompares++;
        $display("[TB] FAIL async_reset dut%0d: outputs %b err %b sc %0d fc %0d, want 11000 err 0 sc 0 fc 0",
                 i, act[i], act_err[i], act_sc[i], act_fc[i]);
      end
    end
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    mem_read = 1; ex_rt = 5'd3; id_rs = 5'd3;
    sample();
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (act[i] !== exp_v[i]) begin
        miscompares++;
        $display("[TB] FAIL after_reset dut%0d: got %b want %b", i, act[i], exp_v[i]);
      end
    end
    tick();
    clear_inputs();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_load_use();
    test_zero_load();
    test_branch_vs_load_use();
    test_membusy_in_bubble();
    test_random();
    test_mem_timeout();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
